echo_lag_frontend: RTL and testbench
====================================

ECHO_LAG_FRONTEND -- requirements
Module: echo_lag_frontend

Interface
REQ-001 Parameter: LAG_DEPTH, 64, far-end delay-line entries (power of two, 2..1024).
REQ-002 Parameter: SIG_W, 16, sample width in bits (two's complement).
REQ-003 Port: clk_operation  in  1  operation clock; sole clock.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: enable  in  1  run request; low parks the FSM in IDLE.
REQ-006 Port: sampling_cycle  in  13  clocks per sample period.
REQ-007 Port: bulk_lag  in  log2(LAG_DEPTH)  far-end delay in sample periods.
REQ-008 Port: in_valid / in_ready  in / out  1 / 1  ADC pair handshake.
REQ-009 Port: near_in / far_in  in  SIG_W each  mic sample / far-end (sent) sample.
REQ-010 Port: sampling_cycle_counter  out  13  free-running period counter for downstream.
REQ-011 Port: sig16b  out  SIG_W  far-end sample delayed bulk_lag periods.
REQ-012 Port: sig16b_lag  out  SIG_W  near-end mic sample (echo-bearing).
REQ-013 Port: underrun  out  1  one-cycle pulse when no sample pair was available at capture.

Function
REQ-014 Counter shall increment each clock in RUN and wrap to 0 when count >= eff_cycle-1; eff_cycle = max(sampling_cycle, 8); a shrink below current count wraps next clock.
REQ-015 FSM states IDLE, RUN, CAPTURE, READ, PUBLISH; IDLE->RUN on enable; RUN->CAPTURE at count==1; CAPTURE->READ->PUBLISH->RUN one clock each; enable low in any state -> IDLE next clock, counter held at 0, outputs held.
REQ-016 In IDLE, in_ready shall be 0.
REQ-017 Holding register: in_ready=1 in non-IDLE states while empty; transfer on in_valid&in_ready; full blocks further transfers (no overrun possible).
REQ-018 CAPTURE: holding full -> consume pair, clear holding; empty -> reuse previous pair and pulse underrun; transfer and capture in same clock: capture wins, transfer accepted next clock.
REQ-019 CAPTURE shall write far sample to RAM at wr_ptr, then wr_ptr increments modulo LAG_DEPTH.
REQ-020 READ shall issue RAM read at (wr_ptr_after_write-1-bulk_lag) mod LAG_DEPTH; bulk_lag sampled in CAPTURE.
REQ-021 Entries never written since reset (fill count <= bulk_lag) shall read as 0; fill count saturates at LAG_DEPTH.
REQ-022 PUBLISH (count==3) shall update sig16b and sig16b_lag together; both stable until next PUBLISH, so downstream sampling at count==0 sees the previous period's pair (one-period latency).
REQ-023 bulk_lag==0 shall yield sig16b equal to the same-period far sample.

Reset
REQ-024 rst_n low: state IDLE, counter 0, sig16b 0, sig16b_lag 0, underrun 0, in_ready 0, holding empty, wr_ptr 0, fill 0; RAM contents not reset.
REQ-025 Reset mid-period shall abort immediately; first post-reset PUBLISH outputs near sample and 0 for far unless bulk_lag==0.

Configuration
REQ-026 Macro ECHO_FRONTEND_STATS_EN defined: add output underrun_count (16 bits, saturating at 65535, cleared by reset) incremented per underrun pulse.
REQ-027 Macro undefined: underrun_count port and logic absent; all other behaviour identical.

Structure
REQ-028 Shared package echo_pkg shall hold SIG_W default, counter width 13, minimum cycle 8, FSM state enum.
REQ-029 Delay line shall be sub-module lag_ram: simple dual-port, one write port, registered synchronous read, no reset.

Verification
REQ-030 sampling_cycle=1200, enable=1 -> counter 0..1199 wraps, PUBLISH at count 3 each period.
REQ-031 bulk_lag=5, far_in ramp 1,2,3... per period -> sig16b 0 for five publishes then 1,2,3...; sig16b_lag tracks near_in with one-period latency.
REQ-032 in_valid withheld for one period -> underrun pulses once, outputs repeat prior near value; stats build: underrun_count=1.
REQ-033 in_valid held high continuously -> exactly one transfer per period, in_ready low while holding full.
REQ-034 rst_n low at count 2 (READ) -> all outputs 0 asynchronously; restart gives sig16b=0 until fill > bulk_lag.
REQ-035 sampling_cycle changed 1200->20 at count 500 -> counter wraps to 0 next clock, no duplicate PUBLISH.

Source files
------------

// File: rtl/echo_pkg.sv
// echo_pkg -- shared definitions for the echo lag front end.
// Holds the default sample width, sample-period counter width, the minimum
// effective sample period and the sequencing FSM state encoding.
package echo_pkg;

    // Default two's complement sample width.
    localparam int SIG_W_DEF = 16;

    // Width of the sample-period counter and the sampling_cycle input.
    localparam int CNT_W = 13;

    // Shortest period the sequencer accepts; CAPTURE..PUBLISH need 4 clocks
    // plus margin so a shrinking period can never cut a sequence short.
    localparam int MIN_CYCLE = 8;

    // Width of the optional saturating underrun statistic.
    localparam int STAT_W = 16;

    // Sequencer states. The RUN state is the idle gap between periods.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_READ    = 3'd3,
        ST_PUBLISH = 3'd4
    } state_t;

    // Effective period length: sampling_cycle clamped from below.
    function automatic logic [CNT_W-1:0] eff_cycle(input logic [CNT_W-1:0] cyc);
        if (cyc < CNT_W'(MIN_CYCLE)) begin
            return CNT_W'(MIN_CYCLE);
        end
        return cyc;
    endfunction

endpackage

// File: rtl/echo_lag_frontend_lag_ram.sv
// lag_ram -- far-end delay line storage.
// Simple dual-port memory: one write port, one registered synchronous read
// port. Contents are deliberately not reset; the front end masks entries
// that were never written since reset.
module lag_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 16,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Write port and registered read port; read data appears one clock after rd_en.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/echo_lag_frontend.sv
// echo_lag_frontend -- sample-period sequencer and far-end delay line.
//
// Each sample period (eff_cycle clocks) the sequencer walks
// RUN -> CAPTURE (count 1) -> READ (count 2) -> PUBLISH (count 3) -> RUN.
// CAPTURE takes the pair from the one-entry holding register (or reuses the
// previous pair and pulses underrun), writes the far sample to the delay
// line, READ fetches the far sample bulk_lag periods back, and PUBLISH
// updates sig16b / sig16b_lag together.
//
// Handshake (in_valid / in_ready): a pair transfers on a clock where both
// are high. in_ready is high only in RUN, READ and PUBLISH while the holding
// register is empty; it is low in IDLE, in CAPTURE (capture has priority, a
// waiting source simply transfers one clock later) and whenever the holding
// register is full, so a pair can never be overwritten.
//
// Optional feature: define ECHO_FRONTEND_STATS_EN to add the 16-bit
// saturating underrun_count output.
module echo_lag_frontend
    import echo_pkg::*;
#(
    parameter int LAG_DEPTH = 64,
    parameter int SIG_W     = SIG_W_DEF,
    localparam int AW       = $clog2(LAG_DEPTH)
) (
    input  logic             clk_operation,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] sampling_cycle,
    input  logic [AW-1:0]    bulk_lag,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] near_in,
    input  logic [SIG_W-1:0] far_in,
    output logic [CNT_W-1:0] sampling_cycle_counter,
    output logic [SIG_W-1:0] sig16b,
    output logic [SIG_W-1:0] sig16b_lag,
    output logic             underrun
`ifdef ECHO_FRONTEND_STATS_EN
    ,
    output logic [STAT_W-1:0] underrun_count
`endif
);

    // Sequencer state; kept as a plain named signal so checkers can bind to it.
    state_t           state;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] eff_m1;
    logic             count_wrap;

    // One-entry holding register between the ADC handshake and CAPTURE.
    logic             hold_full;
    logic [SIG_W-1:0] hold_near;
    logic [SIG_W-1:0] hold_far;
    logic             xfer;

    // Pair used by the current period (reused on underrun).
    logic [SIG_W-1:0] cap_near;
    logic [SIG_W-1:0] cap_far;

    // Delay-line bookkeeping.
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      fill;
    logic [AW-1:0]    lag_s;
    logic             rd_zero;

    logic             ram_wr_en;
    logic [SIG_W-1:0] ram_wr_data;
    logic             ram_rd_en;
    logic [AW-1:0]    ram_rd_addr;
    logic [SIG_W-1:0] ram_rd_data;

    assign sampling_cycle_counter = count;

    // A shrink below the current count makes count_wrap true immediately.
    assign eff_m1     = eff_cycle(sampling_cycle) - CNT_W'(1);
    assign count_wrap = (count >= eff_m1);

    assign in_ready = ((state == ST_RUN) || (state == ST_READ) || (state == ST_PUBLISH))
                      && !hold_full;
    assign xfer     = in_valid && in_ready;

    // The write happens in CAPTURE with the pair being consumed, or the previous
    // far sample when the holding register is empty.
    assign ram_wr_en   = (state == ST_CAPTURE) && enable;
    assign ram_wr_data = hold_full ? hold_far : cap_far;

    // wr_ptr has already advanced past the CAPTURE write when READ issues.
    assign ram_rd_en   = (state == ST_READ);
    assign ram_rd_addr = wr_ptr - AW'(1) - lag_s;

    // Sample-period counter: runs outside IDLE, parked at zero otherwise.
    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || (state == ST_IDLE)) begin
            count <= '0;
        end else if (count_wrap) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Holding register: filled by the handshake, emptied by CAPTURE.
    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_near <= '0;
            hold_far  <= '0;
        end else if ((state == ST_CAPTURE) && enable && hold_full) begin
            hold_full <= 1'b0;
        end else if (xfer) begin
            hold_full <= 1'b1;
            hold_near <= near_in;
            hold_far  <= far_in;
        end
    end

    // Sequencer with registered outputs, delay-line pointers and capture pair.
    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            underrun   <= 1'b0;
            sig16b     <= '0;
            sig16b_lag <= '0;
            cap_near   <= '0;
            cap_far    <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            lag_s      <= '0;
            rd_zero    <= 1'b1;
        end else begin
            underrun <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        // Counter moves 0 -> 1 on this edge, so CAPTURE sits at count 1.
                        if (count == '0) begin
                            state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        state <= ST_READ;
                        if (hold_full) begin
                            cap_near <= hold_near;
                            cap_far  <= hold_far;
                        end else begin
                            underrun <= 1'b1;
                        end
                        wr_ptr <= wr_ptr + 1'b1;
                        if (fill != (AW+1)'(LAG_DEPTH)) begin
                            fill <= fill + 1'b1;
                        end
                        lag_s <= bulk_lag;
                    end
                    ST_READ: begin
                        state   <= ST_PUBLISH;
                        // Entry lag_s periods back was never written since reset.
                        rd_zero <= (fill <= {1'b0, lag_s});
                    end
                    ST_PUBLISH: begin
                        state      <= ST_RUN;
                        sig16b     <= rd_zero ? '0 : ram_rd_data;
                        sig16b_lag <= cap_near;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ECHO_FRONTEND_STATS_EN
    // Saturating count of underrun pulses since reset.
    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != {STAT_W{1'b1}})) begin
            underrun_count <= underrun_count + 1'b1;
        end
    end
`endif

    lag_ram #(
        .DEPTH (LAG_DEPTH),
        .W     (SIG_W),
        .AW    (AW)
    ) u_lag_ram (
        .clk     (clk_operation),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr),
        .wr_data (ram_wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_echo_lag_frontend.sv
// tb_echo_lag_frontend -- self-checking bench for echo_lag_frontend.
// Builds with or without ECHO_FRONTEND_STATS_EN.
module tb_echo_lag_frontend;

  localparam int LAG_DEPTH = 64;
  localparam int SIG_W     = 16;
  localparam int AW        = 6;
  localparam int BOUND     = 3000;

  // ---------------- clock / reset / DUT ----------------
  logic             clk_operation = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [12:0]      sampling_cycle;
  logic [AW-1:0]    bulk_lag;
  logic             in_valid;
  logic             in_ready;
  logic [SIG_W-1:0] near_in;
  logic [SIG_W-1:0] far_in;
  logic [12:0]      sampling_cycle_counter;
  logic [SIG_W-1:0] sig16b;
  logic [SIG_W-1:0] sig16b_lag;
  logic             underrun;
`ifdef ECHO_FRONTEND_STATS_EN
  logic [15:0]      underrun_count;
`endif

  always #5 clk_operation = ~clk_operation;

  echo_lag_frontend #(.LAG_DEPTH(LAG_DEPTH), .SIG_W(SIG_W)) dut (
    .clk_operation          (clk_operation),
    .rst_n                  (rst_n),
    .enable                 (enable),
    .sampling_cycle         (sampling_cycle),
    .bulk_lag               (bulk_lag),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .near_in                (near_in),
    .far_in                 (far_in),
    .sampling_cycle_counter (sampling_cycle_counter),
    .sig16b                 (sig16b),
    .sig16b_lag             (sig16b_lag),
    .underrun               (underrun)
`ifdef ECHO_FRONTEND_STATS_EN
    ,
    .underrun_count         (underrun_count)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int ur_seen = 0;

  // Underrun pulses observed on the DUT port.
  always @(negedge clk_operation) begin
    if (underrun === 1'b1) ur_seen++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles, counter=%0d", name, BOUND, sampling_cycle_counter);
  endtask

  // ---------------- reference model ----------------
  // Period-level model: every capture appends the period's far sample to a
  // history list; the delayed output is the entry bulk_lag captures back, or
  // 0 if that many captures have not happened yet.
  logic [SIG_W-1:0] far_hist[$];
  logic [SIG_W-1:0] cur_near;
  logic [SIG_W-1:0] cur_far;
  logic [32:0]      exp_q[$];   // {underrun, far, near}
  logic [32:0]      last_exp;
  int               ur_base;
  int               ur_model;

  task automatic model_reset();
    far_hist.delete();
    exp_q.delete();
    cur_near = '0;
    cur_far  = '0;
    ur_model = 0;
    last_exp = '0;
  endtask

  task automatic model_capture(input logic give, input logic [SIG_W-1:0] n, input logic [SIG_W-1:0] f);
    logic [SIG_W-1:0] ef;
    int lag;
    lag = int'(bulk_lag);
    if (give) begin
      cur_near = n;
      cur_far  = f;
    end else begin
      ur_model++;
    end
    far_hist.push_back(cur_far);
    if (far_hist.size() > lag) ef = far_hist[far_hist.size() - 1 - lag];
    else ef = '0;
    exp_q.push_back({~give, ef, cur_near});
    ur_base = ur_seen;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_counter(input logic [12:0] v, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_operation);
      n++;
    end while (sampling_cycle_counter !== v && n < BOUND);
    if (n >= BOUND) timeout_fail(name);
  endtask

  task automatic measure_period(output int len);
    len = 0;
    do begin
      @(negedge clk_operation);
      len++;
    end while (sampling_cycle_counter !== 13'd0 && len < BOUND);
  endtask

  task automatic send_pair(input logic [SIG_W-1:0] n, input logic [SIG_W-1:0] f);
    logic ready_s;
    int k;
    near_in  = n;
    far_in   = f;
    in_valid = 1'b1;
    k = 0;
    while (1) begin
      ready_s = in_ready;
      @(posedge clk_operation);
      if (ready_s === 1'b1) break;
      k++;
      if (k >= BOUND) begin
        timeout_fail("send_pair");
        break;
      end
      @(negedge clk_operation);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic check_period(input string name);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      timeout_fail({name, "_noexp"});
      return;
    end
    e = exp_q.pop_front();
    last_exp = e;
    chk({name, "_sig16b"}, 32'(sig16b), 32'(e[31:16]));
    chk({name, "_sig16b_lag"}, 32'(sig16b_lag), 32'(e[15:0]));
    chk({name, "_underrun"}, 32'(ur_seen - ur_base), 32'(e[32]));
  endtask

  task automatic do_period(input logic give, input logic [SIG_W-1:0] n, input logic [SIG_W-1:0] f,
                           input string name);
    model_capture(give, n, f);
    if (give) send_pair(n, f);
    wait_counter(13'd4, name);
    check_period(name);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic             give;
    logic [SIG_W-1:0] near;
    logic [SIG_W-1:0] far;
    logic [SIG_W-1:0] exp_far;
    logic [SIG_W-1:0] exp_near;
    logic             exp_ur;
  } vec_t;

  vec_t tbl[6];

  // ---------------- test sequence ----------------
  initial begin
    int len;
    int xfers;
    int n;
    int base;
    logic [SIG_W-1:0] dn;
    logic [SIG_W-1:0] df;

    // bulk_lag = 2, hand-derived expectations after a fresh reset
    tbl[0] = '{1'b1, 16'h0100, 16'd1, 16'd0, 16'h0100, 1'b0};
    tbl[1] = '{1'b1, 16'h0101, 16'd2, 16'd0, 16'h0101, 1'b0};
    tbl[2] = '{1'b1, 16'h0102, 16'd3, 16'd1, 16'h0102, 1'b0};
    tbl[3] = '{1'b0, 16'h0DEAD, 16'h0BEEF, 16'd2, 16'h0102, 1'b1};
    tbl[4] = '{1'b1, 16'h0104, 16'd5, 16'd3, 16'h0104, 1'b0};
    tbl[5] = '{1'b1, 16'h0105, 16'd6, 16'd3, 16'h0105, 1'b0};

    rst_n          = 1'b0;
    enable         = 1'b0;
    in_valid       = 1'b0;
    sampling_cycle = 13'd1200;
    bulk_lag       = '0;
    near_in        = '0;
    far_in         = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk_operation);
    chk("rst_counter", 32'(sampling_cycle_counter), 0);
    chk("rst_sig16b", 32'(sig16b), 0);
    chk("rst_sig16b_lag", 32'(sig16b_lag), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_in_ready", 32'(in_ready), 0);

    // Released but not enabled: parked in IDLE
    rst_n = 1'b1;
    repeat (3) @(negedge clk_operation);
    chk("idle_counter", 32'(sampling_cycle_counter), 0);
    chk("idle_in_ready", 32'(in_ready), 0);

    // Counter: 1200-clock period, wrap after 1199
    enable = 1'b1;
    wait_counter(13'd1199, "wait_1199");
    @(negedge clk_operation);
    chk("wrap_1200", 32'(sampling_cycle_counter), 0);
    measure_period(len);
    chk("period_1200", 32'(len), 1200);

    // Minimum effective period is 8
    sampling_cycle = 13'd5;
    measure_period(len);
    chk("period_min8", 32'(len), 8);

    // Shrink 1200 -> 20 at count 500: wrap next clock, one capture per period
    sampling_cycle = 13'd1200;
    wait_counter(13'd500, "wait_500");
    sampling_cycle = 13'd20;
    @(negedge clk_operation);
    chk("shrink_wrap", 32'(sampling_cycle_counter), 0);
    base = ur_seen;
    measure_period(len);
    chk("shrink_period", 32'(len), 20);
    chk("shrink_one_capture", 32'(ur_seen - base), 1);

    // Fresh start for the data path
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge clk_operation);
    rst_n = 1'b1;
    model_reset();
    bulk_lag = 6'd2;
    enable   = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      base = ur_seen;
      if (tbl[i].give) send_pair(tbl[i].near, tbl[i].far);
      wait_counter(13'd4, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_sig16b", i), 32'(sig16b), 32'(tbl[i].exp_far));
      chk($sformatf("tbl%0d_sig16b_lag", i), 32'(sig16b_lag), 32'(tbl[i].exp_near));
      chk($sformatf("tbl%0d_underrun", i), 32'(ur_seen - base), 32'(tbl[i].exp_ur));
    end

    // Asynchronous reset during READ (count 2)
    wait_counter(13'd2, "wait_read");
    rst_n = 1'b0;
    #1;
    chk("async_rst_sig16b", 32'(sig16b), 0);
    chk("async_rst_sig16b_lag", 32'(sig16b_lag), 0);
    chk("async_rst_underrun", 32'(underrun), 0);
    chk("async_rst_counter", 32'(sampling_cycle_counter), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    @(negedge clk_operation);
    rst_n = 1'b1;
    model_reset();

    // bulk_lag = 5 with a far ramp: five zero publishes, then 1, 2, 3...
    bulk_lag = 6'd5;
    for (int k = 1; k <= 9; k++) begin
      do_period(1'b1, 16'(16'h0200 + k), 16'(k), $sformatf("ramp%0d", k));
    end

    // in_valid held high: one transfer per period, in_ready low while full
    dn = 16'h1357;
    df = 16'h2468;
    near_in  = dn;
    far_in   = df;
    in_valid = 1'b1;
    model_capture(1'b1, dn, df);
    n = 0;
    do begin
      @(negedge clk_operation);
      n++;
    end while (sampling_cycle_counter !== 13'd4 && n < BOUND);
    if (n >= BOUND) timeout_fail("stream_p1");
    check_period("stream_p1");
    chk("stream_full_ready", 32'(in_ready), 0);
    model_capture(1'b1, dn, df);
    xfers = 0;
    n = 0;
    do begin
      if (in_valid && in_ready) xfers++;
      @(negedge clk_operation);
      n++;
    end while (sampling_cycle_counter !== 13'd4 && n < BOUND);
    if (n >= BOUND) timeout_fail("stream_p2");
    chk("stream_xfers_per_period", 32'(xfers), 1);
    check_period("stream_p2");
    in_valid = 1'b0;
    model_capture(1'b1, dn, df);
    wait_counter(13'd4, "stream_p3");
    check_period("stream_p3");

    // Randomized periods against the model
    for (int k = 0; k < 50; k++) begin
      if (k % 10 == 0) begin
        if ($urandom_range(0, 2) == 0) bulk_lag = 6'd0;
        else bulk_lag = AW'($urandom_range(0, LAG_DEPTH - 1));
      end
      do_period(($urandom_range(0, 5) != 0), 16'($urandom), 16'($urandom),
                $sformatf("rnd%0d", k));
    end

    // bulk_lag = 0: far output equals this period's far sample
    bulk_lag = 6'd0;
    do_period(1'b1, 16'h7ABC, 16'h8001, "lag0");
    chk("lag0_direct", 32'(sig16b), 32'h8001);

    // Enable low parks in IDLE with outputs held
    enable = 1'b0;
    repeat (25) @(negedge clk_operation);
    chk("park_counter", 32'(sampling_cycle_counter), 0);
    chk("park_in_ready", 32'(in_ready), 0);
    chk("park_sig16b", 32'(sig16b), 32'(last_exp[31:16]));
    chk("park_sig16b_lag", 32'(sig16b_lag), 32'(last_exp[15:0]));
    enable = 1'b1;
    bulk_lag = 6'd3;
    for (int k = 0; k < 4; k++) begin
      do_period(1'b1, 16'($urandom), 16'($urandom), $sformatf("resume%0d", k));
    end
    do_period(1'b0, 16'h0, 16'h0, "resume_ur");

`ifdef ECHO_FRONTEND_STATS_EN
    chk("underrun_count", 32'(underrun_count), 32'(ur_model));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
